// File: rtl/iob_spi_fl_arb_pkg.sv
// Shared definitions for the SPI flash arbiter: FSM state encoding,
// FL_COMMAND / FL_COMMANDTP field offsets and the default XIP fast-read
// command words that software normally programs into xip_command/_commandtp.
package iob_spi_fl_arb_pkg;

    typedef logic [2:0] arb_state_t;

    localparam arb_state_t ST_IDLE      = 3'd0;
    localparam arb_state_t ST_LOAD      = 3'd1;
    localparam arb_state_t ST_START     = 3'd2;
    localparam arb_state_t ST_WAIT_BUSY = 3'd3;
    localparam arb_state_t ST_WAIT_DONE = 3'd4;
    localparam arb_state_t ST_RESP      = 3'd5;

    // FL_COMMAND layout: opcode, data bit count, dummy cycle count.
    localparam int FL_CMD_OFF      = 0;
    localparam int FL_NDATA_OFF    = 8;
    localparam int FL_NDUMMY_OFF   = 16;
    // FL_COMMANDTP layout: address byte count, continuous-read flag.
    localparam int FL_TP_ADDRB_OFF = 0;
    localparam int FL_TP_CONT_OFF  = 8;

    // Assemble an FL_COMMAND word from its fields.
    function automatic logic [31:0] fl_command_word(
        input logic [7:0] cmd,
        input logic [6:0] ndata,
        input logic [5:0] ndummy
    );
        logic [31:0] w;
        w = 32'h0000_0000;
        w[FL_CMD_OFF +: 8]    = cmd;
        w[FL_NDATA_OFF +: 7]  = ndata;
        w[FL_NDUMMY_OFF +: 6] = ndummy;
        return w;
    endfunction

    // Fast read 0x0B, 32 data bits, 8 dummy cycles, 3 address bytes.
    localparam logic [31:0] XIP_COMMAND_DEF   = fl_command_word(8'h0B, 7'd32, 6'd8);
    localparam logic [31:0] XIP_COMMANDTP_DEF = 32'h0000_0003;

endpackage

// File: rtl/iob_spi_fl_arb_grant.sv
// Requester priority for the flash arbiter plus the cache burst counter.
// Ports:
//   grant_en    - arbiter is idle and the core is ready
//   cache_req   - cache read request level
//   sw_req      - registered software request pending flag
//   grant_cache - cache wins this cycle (combinational)
//   grant_sw    - software wins this cycle (combinational)
// The cache may win at most CACHE_BURST_MAX times in a row while software waits.
module iob_spi_fl_arb_grant #(
    parameter int CACHE_BURST_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic grant_en,
    input  logic cache_req,
    input  logic sw_req,
    output logic grant_cache,
    output logic grant_sw
);

    localparam int                BW        = $clog2(CACHE_BURST_MAX + 1);
    localparam logic [BW-1:0]     BURST_LIM = BW'(CACHE_BURST_MAX);

    logic [BW-1:0] burst_cnt_r;

    // Pick the winner among pending requests.
    always_comb begin
        grant_cache = 1'b0;
        grant_sw    = 1'b0;
        if (grant_en) begin
            if (cache_req && sw_req) begin
                if (burst_cnt_r < BURST_LIM) begin
                    grant_cache = 1'b1;
                end else begin
                    grant_sw = 1'b1;
                end
            end else if (cache_req) begin
                grant_cache = 1'b1;
            end else if (sw_req) begin
                grant_sw = 1'b1;
            end else begin
                grant_cache = 1'b0;
            end
        end else begin
            grant_sw = 1'b0;
        end
    end

    // Count cache grants taken while software is waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt_r <= '0;
        end else if (grant_sw || !sw_req) begin
            burst_cnt_r <= '0;
        end else if (grant_cache && (burst_cnt_r < BURST_LIM)) begin
            burst_cnt_r <= burst_cnt_r + 1'b1;
        end
    end

endmodule

// File: rtl/iob_spi_fl_arbiter.sv
// Arbiter between the cache read port and the software command registers
// in front of a single spi_master_fl core. One transaction at a time: the
// winner's fields are latched, a one-cycle start pulse is issued, the core's
// idle level is tracked through busy and back, and the read data plus a
// ready/done indication go back to the winner.
// Ports:
//   cache_valid/addr -> cache_rdata/cache_ready   cache read port (XIP)
//   sw_valid/addr/wdata/command/commandtp -> sw_rdata/sw_done   sw port
//   xip_command/xip_commandtp                     command words for cache reads
//   core_valid/addr/wdata/command/commandtp       latched start to the core
//   core_rdata/core_ready                         core result and idle level
//   timeout_err                                   core never went busy after a start
module iob_spi_fl_arbiter
    import iob_spi_fl_arb_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int CACHE_BURST_MAX = 4,
    parameter int TIMEOUT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cache_valid,
    input  logic [ADDR_W-1:0] cache_addr,
    output logic [DATA_W-1:0] cache_rdata,
    output logic              cache_ready,
    input  logic              sw_valid,
    input  logic [ADDR_W-1:0] sw_addr,
    input  logic [DATA_W-1:0] sw_wdata,
    input  logic [31:0]       sw_command,
    input  logic [31:0]       sw_commandtp,
    output logic [DATA_W-1:0] sw_rdata,
    output logic              sw_done,
    input  logic [31:0]       xip_command,
    input  logic [31:0]       xip_commandtp,
    output logic              core_valid,
    output logic [ADDR_W-1:0] core_addr,
    output logic [DATA_W-1:0] core_wdata,
    output logic [31:0]       core_command,
    output logic [31:0]       core_commandtp,
    input  logic [DATA_W-1:0] core_rdata,
    input  logic              core_ready,
    output logic              timeout_err
);

    // Last watchdog value before giving up: 2^TIMEOUT_W-1 cycles in WAIT_BUSY.
    localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    arb_state_t           state_r;
    arb_state_t           state_nxt_s;
    logic                 owner_sw_r;
    logic                 sw_pend_r;
    logic [TIMEOUT_W-1:0] wd_cnt_r;

    logic                 grant_en_s;
    logic                 grant_cache_s;
    logic                 grant_sw_s;
    logic                 sw_accept_s;
    logic                 done_s;
    logic                 timeout_s;
    logic                 resp_s;
    logic [DATA_W-1:0]    resp_data_s;

    logic [DATA_W-1:0]    cache_rdata_r;
    logic                 cache_ready_r;
    logic [DATA_W-1:0]    sw_rdata_r;
    logic                 sw_done_r;
    logic                 core_valid_r;
    logic [ADDR_W-1:0]    core_addr_r;
    logic [DATA_W-1:0]    core_wdata_r;
    logic [31:0]          core_command_r;
    logic [31:0]          core_commandtp_r;
    logic                 timeout_err_r;

    assign cache_rdata    = cache_rdata_r;
    assign cache_ready    = cache_ready_r;
    assign sw_rdata       = sw_rdata_r;
    assign sw_done        = sw_done_r;
    assign core_valid     = core_valid_r;
    assign core_addr      = core_addr_r;
    assign core_wdata     = core_wdata_r;
    assign core_command   = core_command_r;
    assign core_commandtp = core_commandtp_r;
    assign timeout_err    = timeout_err_r;

    assign grant_en_s = (state_r == ST_IDLE) && core_ready;

    iob_spi_fl_arb_grant #(
        .CACHE_BURST_MAX (CACHE_BURST_MAX)
    ) u_grant (
        .clk         (clk),
        .rst_n       (rst_n),
        .grant_en    (grant_en_s),
        .cache_req   (cache_valid),
        .sw_req      (sw_pend_r),
        .grant_cache (grant_cache_s),
        .grant_sw    (grant_sw_s)
    );

    // A sw strobe is dropped while one is already queued or in flight.
    assign sw_accept_s = sw_valid && !sw_pend_r && !((state_r != ST_IDLE) && owner_sw_r);
    assign done_s      = (state_r == ST_WAIT_DONE) && core_ready;
    assign timeout_s   = (state_r == ST_WAIT_BUSY) && core_ready && (wd_cnt_r == WD_LAST);
    assign resp_s      = done_s || timeout_s;

    // Response data: core result on completion, zero on watchdog expiry.
    always_comb begin
        resp_data_s = '0;
        if (done_s) begin
            resp_data_s = core_rdata;
        end else begin
            resp_data_s = '0;
        end
    end

    // Next-state logic for the transaction sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_cache_s || grant_sw_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD:  state_nxt_s = ST_START;
            ST_START: state_nxt_s = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (!core_ready) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else if (wd_cnt_r == WD_LAST) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (core_ready) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            ST_RESP:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State register, winner record and start-acknowledge watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            owner_sw_r <= 1'b0;
            wd_cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (grant_cache_s || grant_sw_s) begin
                owner_sw_r <= grant_sw_s;
            end
            if (state_r == ST_START) begin
                wd_cnt_r <= '0;
            end else if ((state_r == ST_WAIT_BUSY) && core_ready && (wd_cnt_r != WD_LAST)) begin
                wd_cnt_r <= wd_cnt_r + 1'b1;
            end
        end
    end

    // Software request pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_pend_r <= 1'b0;
        end else if (grant_sw_s) begin
            sw_pend_r <= 1'b0;
        end else if (sw_accept_s) begin
            sw_pend_r <= 1'b1;
        end
    end

    // Latch the winner's fields at grant so they are stable from LOAD on; start pulse in START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_valid_r     <= 1'b0;
            core_addr_r      <= '0;
            core_wdata_r     <= '0;
            core_command_r   <= 32'h0000_0000;
            core_commandtp_r <= 32'h0000_0000;
        end else begin
            core_valid_r <= (state_r == ST_LOAD);
            if (grant_cache_s) begin
                core_addr_r      <= cache_addr;
                core_wdata_r     <= '0;
                core_command_r   <= xip_command;
                core_commandtp_r <= xip_commandtp;
            end else if (grant_sw_s) begin
                core_addr_r      <= sw_addr;
                core_wdata_r     <= sw_wdata;
                core_command_r   <= sw_command;
                core_commandtp_r <= sw_commandtp;
            end
        end
    end

    // Route the result to the winner; done and error flags are sticky until the next sw strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_rdata_r <= '0;
            cache_ready_r <= 1'b0;
            sw_rdata_r    <= '0;
            sw_done_r     <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            cache_ready_r <= resp_s && !owner_sw_r;
            if (resp_s && !owner_sw_r) begin
                cache_rdata_r <= resp_data_s;
            end
            if (resp_s && owner_sw_r) begin
                sw_rdata_r <= resp_data_s;
                sw_done_r  <= 1'b1;
            end else if (sw_valid) begin
                sw_done_r <= 1'b0;
            end
            if (timeout_s) begin
                timeout_err_r <= 1'b1;
            end else if (sw_valid) begin
                timeout_err_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iob_spi_fl_arbiter.sv
// Self-checking bench for iob_spi_fl_arbiter: a behavioural flash core that
// answers from a flash content model, a cache/software requester sequence,
// and expectations derived from the arbitration rules.
module tb_iob_spi_fl_arbiter;

    localparam int BURST = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cache_valid;
    logic [31:0] cache_addr;
    logic [31:0] cache_rdata;
    logic        cache_ready;
    logic        sw_valid;
    logic [31:0] sw_addr, sw_wdata, sw_command, sw_commandtp;
    logic [31:0] sw_rdata;
    logic        sw_done;
    logic [31:0] xip_command, xip_commandtp;
    logic        core_valid;
    logic [31:0] core_addr, core_wdata, core_command, core_commandtp;
    logic [31:0] core_rdata;
    logic        core_ready;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    iob_spi_fl_arbiter #(
        .ADDR_W(32), .DATA_W(32), .CACHE_BURST_MAX(BURST), .TIMEOUT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cache_valid(cache_valid), .cache_addr(cache_addr),
        .cache_rdata(cache_rdata), .cache_ready(cache_ready),
        .sw_valid(sw_valid), .sw_addr(sw_addr), .sw_wdata(sw_wdata),
        .sw_command(sw_command), .sw_commandtp(sw_commandtp),
        .sw_rdata(sw_rdata), .sw_done(sw_done),
        .xip_command(xip_command), .xip_commandtp(xip_commandtp),
        .core_valid(core_valid), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_command(core_command), .core_commandtp(core_commandtp),
        .core_rdata(core_rdata), .core_ready(core_ready),
        .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] command;
        logic [31:0] commandtp;
    } start_t;

    start_t started_q[$];
    logic   core_dead = 1'b0;
    int     core_busy = 4;

    // Flash content model.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1357};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_sig(input int which, input int limit, output int lat);
        lat = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if ((which == 0 && cache_ready) || (which == 1 && sw_done)) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic sw_issue(input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] cmd, input logic [31:0] tp);
        sw_addr = a; sw_wdata = wd; sw_command = cmd; sw_commandtp = tp;
        sw_valid = 1'b1;
        @(negedge clk);
        sw_valid = 1'b0;
    endtask

    // Behavioural flash core: goes busy on a start, answers after core_busy cycles.
    initial begin
        start_t s;
        core_ready = 1'b1;
        core_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                core_ready = 1'b1;
            end else if (core_valid && !core_dead) begin
                s.addr = core_addr; s.wdata = core_wdata;
                s.command = core_command; s.commandtp = core_commandtp;
                started_q.push_back(s);
                core_ready = 1'b0;
                for (int k = 0; k < core_busy; k++) begin
                    @(negedge clk);
                    if (!rst_n) break;
                    if (k == 0) chk("core_valid_one_cycle", 32'(core_valid), 32'h0);
                    chk("stable_addr", core_addr, s.addr);
                    chk("stable_command", core_command, s.command);
                    chk("stable_wdata", core_wdata, s.wdata);
                end
                core_rdata = mem_rd(s.addr);
                core_ready = 1'b1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        start_t      e;
        int          n0, lat, pos, extra;
        logic        sw_seen, c_seen, got;
        logic [31:0] a, wd, ca, swcmd;

        rst_n = 1'b0; cache_valid = 1'b0; cache_addr = 32'h0; sw_valid = 1'b0;
        sw_addr = 32'h0; sw_wdata = 32'h0; sw_command = 32'h0; sw_commandtp = 32'h0;
        xip_command = 32'h0008_200B; xip_commandtp = 32'h0000_0003;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_cache_rdata", cache_rdata, 32'h0);
        chk("rst_cache_ready", 32'(cache_ready), 32'h0);
        chk("rst_sw_done", 32'(sw_done), 32'h0);
        chk("rst_core_valid", 32'(core_valid), 32'h0);
        chk("rst_core_command", core_command, 32'h0);
        chk("rst_timeout_err", 32'(timeout_err), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Cache read of 0x100
        core_busy = 10; n0 = started_q.size();
        cache_addr = 32'h0000_0100; cache_valid = 1'b1;
        wait_sig(0, 100, lat);
        cache_valid = 1'b0;
        chk("c1_ready_seen", 32'(lat > 0), 32'h1);
        chk("c1_rdata", cache_rdata, 32'hDEAD_BEEF);
        chk("c1_starts", 32'(started_q.size() - n0), 32'h1);
        if (started_q.size() > n0) begin
            e = started_q[n0];
            chk("c1_command", e.command, xip_command);
            chk("c1_commandtp", e.commandtp, xip_commandtp);
            chk("c1_addr", e.addr, 32'h0000_0100);
            chk("c1_wdata", e.wdata, 32'h0);
        end
        @(negedge clk);
        chk("c1_ready_pulse", 32'(cache_ready), 32'h0);

        // Software command, then a second one clearing the sticky done
        for (int r = 0; r < 2; r++) begin
            a = $urandom; wd = $urandom; core_busy = $urandom_range(2, 12);
            swcmd = (r == 0) ? 32'h0000_2006 : 32'h0000_2002;
            n0 = started_q.size();
            sw_issue(a, wd, swcmd, 32'h0000_0103);
            chk("sw_done_cleared", 32'(sw_done), 32'h0);
            wait_sig(1, 200, lat);
            chk("sw_done_seen", 32'(lat > 0), 32'h1);
            chk("sw_rdata", sw_rdata, mem_rd(a));
            if (started_q.size() > n0) begin
                e = started_q[n0];
                chk("sw_addr", e.addr, a);
                chk("sw_wdata", e.wdata, wd);
                chk("sw_command", e.command, swcmd);
                chk("sw_commandtp", e.commandtp, 32'h0000_0103);
            end else begin
                chk("sw_started", 32'(started_q.size() - n0), 32'h1);
            end
            repeat (3) @(negedge clk);
            chk("sw_done_sticky", 32'(sw_done), 32'h1);
        end

        // Contention: cache held continuously, one sw strobe per round
        swcmd = 32'h0000_2003;
        cache_addr = $urandom; cache_valid = 1'b1;
        for (int r = 0; r < 2; r++) begin
            core_busy = $urandom_range(6, 12);
            got = 1'b0;
            for (int i = 0; i < 100 && !got; i++) begin
                @(negedge clk);
                if (cache_ready) begin
                    chk("cont_pre_rdata", cache_rdata, mem_rd(cache_addr));
                    cache_addr = $urandom;
                end
                if (!core_ready) got = 1'b1;
            end
            chk("cont_busy_seen", 32'(got), 32'h1);
            n0 = started_q.size();
            a = $urandom;
            sw_issue(a, 32'h0, swcmd, 32'h0000_0003);
            sw_seen = 1'b0; extra = 0;
            for (int i = 0; i < 3000 && extra < 2; i++) begin
                @(negedge clk);
                if (cache_ready) begin
                    chk("cont_cache_rdata", cache_rdata, mem_rd(cache_addr));
                    cache_addr = $urandom;
                    if (sw_seen) extra++;
                end
                if (sw_done && !sw_seen) begin
                    sw_seen = 1'b1;
                    chk("cont_sw_rdata", sw_rdata, mem_rd(a));
                end
            end
            chk("cont_sw_served", 32'(sw_seen), 32'h1);
            chk("cont_cache_resumed", 32'(extra), 32'h2);
            pos = -1;
            for (int k = n0; k < started_q.size(); k++)
                if (pos < 0 && started_q[k].command == swcmd) pos = k;
            chk("cont_cache_grants_before_sw", 32'(pos - n0), 32'(BURST));
        end
        cache_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Simultaneous cache_valid and sw_valid in IDLE
        n0 = started_q.size(); core_busy = $urandom_range(2, 8);
        ca = $urandom; a = $urandom;
        cache_addr = ca; cache_valid = 1'b1;
        sw_issue(a, 32'h0, swcmd, 32'h0000_0003);
        c_seen = 1'b0; sw_seen = 1'b0;
        for (int i = 0; i < 500 && !(c_seen && sw_seen); i++) begin
            @(negedge clk);
            if (cache_ready && !c_seen) begin
                c_seen = 1'b1; cache_valid = 1'b0;
                chk("sim_cache_rdata", cache_rdata, mem_rd(ca));
            end
            if (sw_done && !sw_seen) begin
                sw_seen = 1'b1;
                chk("sim_sw_rdata", sw_rdata, mem_rd(a));
            end
        end
        cache_valid = 1'b0;
        chk("sim_both_served", 32'(c_seen && sw_seen), 32'h1);
        chk("sim_starts", 32'(started_q.size() - n0), 32'h2);
        if (started_q.size() >= n0 + 2) begin
            chk("sim_first_cmd", started_q[n0].command, xip_command);
            chk("sim_first_addr", started_q[n0].addr, ca);
            chk("sim_second_cmd", started_q[n0+1].command, swcmd);
            chk("sim_second_addr", started_q[n0+1].addr, a);
        end
        repeat (2) @(negedge clk);

        // Dead core: never leaves idle after the start
        core_dead = 1'b1;
        cache_addr = $urandom | 32'h1; cache_valid = 1'b1;
        wait_sig(0, 400, lat);
        cache_valid = 1'b0;
        chk("to_ready_seen", 32'(lat > 0), 32'h1);
        chk("to_latency_window", 32'(lat >= 256 && lat <= 262), 32'h1);
        chk("to_rdata_zero", cache_rdata, 32'h0);
        chk("to_err_set", 32'(timeout_err), 32'h1);
        core_dead = 1'b0;
        repeat (3) @(negedge clk);
        chk("to_err_sticky", 32'(timeout_err), 32'h1);
        a = $urandom; core_busy = 3;
        sw_issue(a, 32'h0, swcmd, 32'h0000_0003);
        chk("to_err_cleared", 32'(timeout_err), 32'h0);
        wait_sig(1, 200, lat);
        chk("to_recover_done", 32'(lat > 0), 32'h1);
        chk("to_recover_rdata", sw_rdata, mem_rd(a));

        // Reset asserted during WAIT_DONE
        core_busy = 20; ca = $urandom | 32'h1;
        cache_addr = ca; cache_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (!core_ready) got = 1'b1;
        end
        repeat (3) @(negedge clk);
        chk("prerst_core_addr", core_addr, ca);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_core_addr", core_addr, 32'h0);
        chk("arst_core_command", core_command, 32'h0);
        chk("arst_cache_rdata", cache_rdata, 32'h0);
        chk("arst_sw_rdata", sw_rdata, 32'h0);
        chk("arst_sw_done", 32'(sw_done), 32'h0);
        chk("arst_core_valid", 32'(core_valid), 32'h0);
        cache_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        core_busy = $urandom_range(2, 10); ca = $urandom;
        cache_addr = ca; cache_valid = 1'b1;
        wait_sig(0, 100, lat);
        cache_valid = 1'b0;
        chk("postrst_ready_seen", 32'(lat > 0), 32'h1);
        chk("postrst_rdata", cache_rdata, mem_rd(ca));
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iob_spi_fl_arbiter.md
Name: iob_spi_fl_arbiter

Overview:
Sits between the two flash requesters (CPU instruction/data cache read port and software command registers) and the single spi_master_fl core. Arbitrates one transaction at a time and latches every command field so the core sees stable inputs. Issues a one-cycle start pulse, tracks completion, and routes read data and a ready pulse back to the winning requester. Cache reads use a software-configured XIP read command.

Parameters:
ADDR_W, 32, flash byte-address width.
DATA_W, 32, read/write data width.
CACHE_BURST_MAX, 4, consecutive cache grants allowed while a sw request waits.
TIMEOUT_W, 8, width of the start-acknowledge watchdog counter.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cache_valid  in  1  cache read request, level, held until cache_ready
cache_addr  in  ADDR_W  cache read address
cache_rdata  out  DATA_W  read data to cache
cache_ready  out  1  one-cycle completion pulse to cache
sw_valid  in  1  one-cycle sw command strobe (FL_VALIDFLG)
sw_addr  in  ADDR_W  sw address
sw_wdata  in  DATA_W  sw write data
sw_command  in  32  sw command word (FL_COMMAND layout)
sw_commandtp  in  32  sw command type word (FL_COMMANDTP layout)
sw_rdata  out  DATA_W  sw read data
sw_done  out  1  sticky done flag, cleared by the next sw_valid
xip_command  in  32  command word for cache reads
xip_commandtp  in  32  command type word for cache reads
core_valid  out  1  start pulse to core
core_addr  out  ADDR_W  latched address
core_wdata  out  DATA_W  latched write data
core_command  out  32  latched command
core_commandtp  out  32  latched command type
core_rdata  in  DATA_W  core read data
core_ready  in  1  core idle level; low while busy
timeout_err  out  1  sticky, core never left idle after a start

Behaviour:
- Reset values: all outputs 0, except core_ready, which is an input. State IDLE, sw_pend=0, burst_cnt=0.
- sw_pend: set on sw_valid, cleared on sw grant. A sw_valid while sw_pend=1 or a sw transaction is in flight is dropped. sw_valid also clears sw_done and timeout_err.
- Grant in IDLE with core_ready=1:
  - Only one request pending: it wins.
  - Both pending: cache wins if burst_cnt<CACHE_BURST_MAX, else sw.
- burst_cnt: increments on a cache grant while sw_pend=1; resets to 0 on a sw grant or when sw_pend=0.
- FSM IDLE -> LOAD -> START -> WAIT_BUSY -> WAIT_DONE -> RESP -> IDLE.
  - LOAD (1 cycle): register addr, wdata, command, commandtp from the winner. Cache uses cache_addr, 0, xip_command, xip_commandtp.
  - START (1 cycle): core_valid=1.
  - WAIT_BUSY: wait for core_ready=0, then go to WAIT_DONE. Watchdog counts cycles; at 2^TIMEOUT_W-1, set timeout_err and go to RESP with rdata=0.
  - WAIT_DONE: on core_ready=1, capture core_rdata and go to RESP.
  - RESP (1 cycle):
    - Cache winner: cache_rdata updated, cache_ready=1.
    - Sw winner: sw_rdata updated, sw_done=1.
- Latched core_* fields are stable from LOAD until the next LOAD.
- Minimum latency from grant to ready is 4 cycles plus core busy time.
- Simultaneous cache_valid and sw_valid in IDLE: sw_valid is registered first, so cache wins that cycle and sw wins on the next grant, subject to the burst rule.
- cache_valid dropped mid-transaction: the transaction completes and cache_ready still pulses. The cache is required to ignore it.
- rst_n low mid-transaction: immediate return to IDLE with all outputs 0. The core is reset by the same net.

Decomposition:
- Package iob_spi_fl_arb_pkg holds:
  - state enum (6 states, 3-bit encoding);
  - FL_COMMAND / FL_COMMANDTP field offsets;
  - default XIP fast-read word (cmd 0x0B, 8 dummy cycles, 32 data bits).
- One sub-module is natural: iob_spi_fl_arb_grant, combinational priority plus the registered burst counter.
- The FSM, latches and watchdog stay in the top.

Test Plan:
- Cache read only: cache_valid, addr 0x000100. Core model busy 10 cycles, rdata 0xDEADBEEF -> core_command==xip_command, core_addr 0x100, cache_ready pulse with rdata 0xDEADBEEF.
- Sw command: sw_valid with command 0x0000_2006 -> core_valid exactly 1 cycle, core fields stable during busy, sw_done=1 after done, cleared by the next sw_valid.
- Contention: cache_valid held continuously plus one sw_valid -> exactly 4 cache grants, then the sw grant, then cache resumes. burst_cnt returns to 0.
- Simultaneous cache_valid and sw_valid in the same IDLE cycle -> cache served first, sw second, no request dropped.
- Dead core: core_ready stuck at 1 after start -> timeout_err after 255 cycles, requester ready/done asserted with rdata 0, FSM back in IDLE.
- Reset asserted during WAIT_DONE -> all outputs 0 asynchronously. After release, a new cache read completes normally.
